// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: 2-FF line synchronizer and mid-bit sampling FSM.
// Good bytes strobe rx_valid; a low stop bit strobes frame_err once per break.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int C  = CLKS_PER_BIT;
    localparam int H  = C / 2;
    localparam int CW = $clog2(C);
    localparam logic [CW-1:0] START_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(C - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sync;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_err;
    logic            r_busy;
    logic            w_rx_s;

    assign w_rx_s    = r_sync[1];
    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_err;
    assign rx_busy   = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == START_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= DATA;
                            r_bit   <= 3'd0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid-stop lets an immediately following start bit be caught.
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are generated from byte lists and
// every pulse is checked against a frame-timing model (pulse at start edge + 2 + H + 9C + 1).
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int C   = 16;
    localparam int H   = C / 2;
    localparam int LAT = 2 + H + 9 * C + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int both_high = 0;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] data;
    } ev_t;
    ev_t ev_q[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder: one line per received transaction.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err)) begin
            ev_t e;
            if (rx_valid && frame_err) both_high++;
            e.cyc  = cyc;
            e.err  = frame_err;
            e.data = rx_data;
            ev_q.push_back(e);
            $display("cycle %0d: %s data=0x%02h", cyc, frame_err ? "frame_err" : "rx_valid", rx_data);
        end
    end

    // Drive tasks assume the phase #1 after a rising edge.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int k);
        for (int i = 0; i < k; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int n);
        n = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy got %b want 0", rx_busy); end
        rst_n = 1'b1;
        realign();
        idle_bits(1);
    endtask

    task automatic test_single();
        int n;
        ev_q.delete();
        send_frame(8'hA5, 1'b1, n);
        idle_bits(2);
        checks++;
        if (ev_q.size() !== 1) begin
            errors++; $display("FAIL single_count got %0d want 1", ev_q.size());
        end else begin
            checks++; if (ev_q[0].err !== 1'b0) begin errors++; $display("FAIL single_kind got err=%b want 0", ev_q[0].err); end
            checks++; if (ev_q[0].data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", ev_q[0].data); end
            checks++; if (ev_q[0].cyc !== n + LAT) begin errors++; $display("FAIL single_time got %0d want %0d", ev_q[0].cyc, n + LAT); end
        end
        @(negedge clk);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", rx_busy); end
        realign();
    endtask

    task automatic test_back_to_back();
        int n0, n1, n2;
        logic [7:0] exp_d [3];
        int exp_c [3];
        ev_q.delete();
        send_frame(8'h00, 1'b1, n0);
        send_frame(8'hFF, 1'b1, n1);
        idle_bits(3);
        send_frame(8'h5A, 1'b1, n2);
        idle_bits(2);
        exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h5A;
        exp_c[0] = n0 + LAT; exp_c[1] = n1 + LAT; exp_c[2] = n2 + LAT;
        checks++;
        if (ev_q.size() !== 3) begin
            errors++; $display("FAIL b2b_count got %0d want 3", ev_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (ev_q[i].err !== 1'b0 || ev_q[i].data !== exp_d[i]) begin
                    errors++; $display("FAIL b2b_data[%0d] got err=%b %h want err=0 %h", i, ev_q[i].err, ev_q[i].data, exp_d[i]);
                end
                checks++; if (ev_q[i].cyc !== exp_c[i]) begin
                    errors++; $display("FAIL b2b_time[%0d] got %0d want %0d", i, ev_q[i].cyc, exp_c[i]);
                end
            end
            checks++; if (ev_q[1].cyc - ev_q[0].cyc !== 10 * C) begin
                errors++; $display("FAIL b2b_spacing got %0d want %0d", ev_q[1].cyc - ev_q[0].cyc, 10 * C);
            end
        end
    endtask

    task automatic test_glitch();
        int n, m;
        ev_q.delete();
        n = cyc;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        wait_cyc(n + 2 + 2);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got %b want 1", rx_busy); end
        wait_cyc(n + 2 + 9);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low got %b want 0", rx_busy); end
        realign();
        idle_bits(2);
        checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL glitch_no_pulse got %0d pulses want 0", ev_q.size()); end
        ev_q.delete();
        send_frame(8'h3C, 1'b1, m);
        idle_bits(2);
        checks++;
        if (ev_q.size() !== 1) begin
            errors++; $display("FAIL glitch_follow_count got %0d want 1", ev_q.size());
        end else begin
            checks++; if (ev_q[0].err !== 1'b0 || ev_q[0].data !== 8'h3C || ev_q[0].cyc !== m + LAT) begin
                errors++; $display("FAIL glitch_follow got err=%b %h @%0d want err=0 3c @%0d", ev_q[0].err, ev_q[0].data, ev_q[0].cyc, m + LAT);
            end
        end
    endtask

    task automatic test_bad_stop();
        int n0, n1;
        ev_q.delete();
        send_frame(8'h11, 1'b1, n0);
        idle_bits(1);
        send_frame(8'h3C, 1'b0, n1);
        idle_bits(2);
        checks++;
        if (ev_q.size() !== 2) begin
            errors++; $display("FAIL badstop_count got %0d want 2", ev_q.size());
        end else begin
            checks++; if (ev_q[0].err !== 1'b0 || ev_q[0].data !== 8'h11) begin
                errors++; $display("FAIL badstop_prior got err=%b %h want err=0 11", ev_q[0].err, ev_q[0].data);
            end
            checks++; if (ev_q[1].err !== 1'b1) begin errors++; $display("FAIL badstop_kind got err=%b want 1", ev_q[1].err); end
            checks++; if (ev_q[1].cyc !== n1 + LAT) begin errors++; $display("FAIL badstop_time got %0d want %0d", ev_q[1].cyc, n1 + LAT); end
        end
        @(negedge clk);
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL badstop_data_kept got %h want 11", rx_data); end
        realign();
    endtask

    task automatic test_break();
        int n, m;
        ev_q.delete();
        n = cyc;
        for (int i = 0; i < 40; i++) drive_bit(1'b0);
        @(negedge clk);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_busy_during got %b want 1", rx_busy); end
        realign();
        rx = 1'b1;
        m = cyc;
        wait_cyc(m + 6);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy_after got %b want 0", rx_busy); end
        realign();
        idle_bits(2);
        checks++;
        if (ev_q.size() !== 1) begin
            errors++; $display("FAIL break_err_count got %0d want 1", ev_q.size());
        end else begin
            checks++; if (ev_q[0].err !== 1'b1 || ev_q[0].cyc !== n + LAT) begin
                errors++; $display("FAIL break_err got err=%b @%0d want err=1 @%0d", ev_q[0].err, ev_q[0].cyc, n + LAT);
            end
        end
        ev_q.delete();
        send_frame(8'h81, 1'b1, m);
        idle_bits(2);
        checks++;
        if (ev_q.size() !== 1 || ev_q[0].err !== 1'b0 || ev_q[0].data !== 8'h81) begin
            errors++; $display("FAIL break_recovery got %0d pulses want one rx_valid with 81", ev_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int m;
        b = 8'hC3;
        ev_q.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (H) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got data=%h v=%b e=%b b=%b want 00 0 0 0", rx_data, rx_valid, frame_err, rx_busy);
        end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_bits(12);
        checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL midreset_no_pulse got %0d pulses want 0", ev_q.size()); end
        ev_q.delete();
        send_frame(8'h7E, 1'b1, m);
        idle_bits(2);
        checks++;
        if (ev_q.size() !== 1 || ev_q[0].err !== 1'b0 || ev_q[0].data !== 8'h7E || ev_q[0].cyc !== m + LAT) begin
            errors++; $display("FAIL midreset_follow got %0d pulses want one rx_valid 7e @%0d", ev_q.size(), m + LAT);
        end
    endtask

    task automatic test_random();
        ev_t exp_q[$];
        ev_t e;
        logic [7:0] b;
        logic [7:0] last_good;
        logic stop;
        int n, gap;
        ev_q.delete();
        for (int i = 0; i < 8; i++) begin
            b    = 8'($urandom_range(0, 255));
            stop = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            gap  = stop ? $urandom_range(0, 3) : $urandom_range(1, 3);
            send_frame(b, stop, n);
            idle_bits(gap);
            if (stop) last_good = b;
            e.cyc = n + LAT; e.err = !stop; e.data = last_good;
            exp_q.push_back(e);
        end
        idle_bits(2);
        checks++;
        if (ev_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL random_count got %0d want %0d", ev_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (ev_q[i].cyc !== exp_q[i].cyc || ev_q[i].err !== exp_q[i].err || ev_q[i].data !== exp_q[i].data) begin
                    errors++; $display("FAIL random[%0d] got err=%b %h @%0d want err=%b %h @%0d", i,
                        ev_q[i].err, ev_q[i].data, ev_q[i].cyc, exp_q[i].err, exp_q[i].data, exp_q[i].cyc);
                end
            end
        end
        @(negedge clk);
        checks++; if (rx_data !== last_good) begin errors++; $display("FAIL random_last_data got %h want %h", rx_data, last_good); end
        realign();
    endtask

    task automatic test_exclusive();
        checks++; if (both_high !== 0) begin errors++; $display("FAIL pulse_exclusive got %0d overlaps want 0", both_high); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_bad_stop();
        test_break();
        test_reset_mid();
        test_random();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got no completion want finish");
        $fatal(1);
    end
endmodule
